// File: rtl/gpio_mux_pkg.sv
// gpio_mux_pkg: shared constants for the Wishbone GPIO pad router.
//   - Register word offsets (wbs_adr_i[4:2]) for the register block.
//   - Reset values of the software registers, kept 32 bits wide and sliced
//     to NUM_IO by the users.
package gpio_mux_pkg;

    localparam logic [2:0] OFS_SRC_SEL  = 3'd0;  // 0x00
    localparam logic [2:0] OFS_OUT_DATA = 3'd1;  // 0x04
    localparam logic [2:0] OFS_OEB_REG  = 3'd2;  // 0x08
    localparam logic [2:0] OFS_IN_DATA  = 3'd3;  // 0x0C
    localparam logic [2:0] OFS_IRQ_EN   = 3'd4;  // 0x10
    localparam logic [2:0] OFS_IRQ_STAT = 3'd5;  // 0x14
    localparam logic [2:0] OFS_IRQ_EDGE = 3'd6;  // 0x18

    localparam logic [31:0] RST_SRC_SEL  = 32'h0000_0000;  // core owns every pin
    localparam logic [31:0] RST_OUT_DATA = 32'h0000_0000;
    localparam logic [31:0] RST_OEB_REG  = 32'hFFFF_FFFF;  // register-owned pins float
    localparam logic [31:0] RST_IRQ_EN   = 32'h0000_0000;
    localparam logic [31:0] RST_IRQ_STAT = 32'h0000_0000;
    localparam logic [31:0] RST_IRQ_EDGE = 32'h0000_0000;

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: input conditioning for asynchronous pad inputs.
//   Each bit passes a 2-flop synchroniser followed by a "previous" flop; the
//   edge output pulses for one cycle when the synchronised value changes in
//   the selected direction.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset (all flops to 0)
//   d_i         raw asynchronous inputs
//   fall_sel_i  per bit: 1 = detect falling edges, 0 = detect rising edges
//   sync_o      synchronised inputs (stage 2)
//   edge_o      one-cycle edge pulse per bit
module gpio_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [WIDTH-1:0] fall_sel_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] edge_o
);

    logic [WIDTH-1:0] s1_q, s2_q, prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign sync_o = s2_q;
    // Pulse sits between the edge that updates stage 2 and the one that
    // updates prev, so the status bit it feeds sets 3 edges after the pin.
    assign edge_o = (fall_sel_i & ~s2_q & prev_q) | (~fall_sel_i & s2_q & ~prev_q);

endmodule

// File: rtl/wb_gpio_mux.sv
// wb_gpio_mux: Wishbone-controlled pad router for the user project area.
//   Per pin the pad is driven either by the user core or by software
//   registers; inputs are synchronised and raise sticky edge interrupts that
//   combine into one registered level IRQ.
// Configuration macro: GPIO_FALLING_EDGE_EN adds the IRQ_EDGE register (0x18)
//   that selects falling-edge detection per pin; without it 0x18 is unmapped.
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   wbs_*                   Wishbone classic slave (single access, 1-cycle ack)
//   core_io_out/core_io_oeb pad value / output-enable-bar from the user core
//   io_in                   raw asynchronous pad inputs
//   io_out/io_oeb           pad value / output-enable-bar (0 = drive)
//   irq                     level interrupt
module wb_gpio_mux
    import gpio_mux_pkg::*;
#(
    parameter int unsigned NUM_IO    = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFE0
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [NUM_IO-1:0] core_io_out,
    input  logic [NUM_IO-1:0] core_io_oeb,
    input  logic [NUM_IO-1:0] io_in,
    output logic [NUM_IO-1:0] io_out,
    output logic [NUM_IO-1:0] io_oeb,
    output logic              irq
);

    // Byte-lane merge of write data into an NUM_IO-wide register.
    function automatic logic [NUM_IO-1:0] lane_merge(input logic [NUM_IO-1:0] old,
                                                     input logic [31:0]       dat,
                                                     input logic [3:0]        sel);
        logic [31:0] full;
        full = '0;
        full[NUM_IO-1:0] = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) full[8*b +: 8] = dat[8*b +: 8];
        end
        return full[NUM_IO-1:0];
    endfunction

    logic [NUM_IO-1:0] src_sel_q, src_sel_d;
    logic [NUM_IO-1:0] out_data_q, out_data_d;
    logic [NUM_IO-1:0] oeb_reg_q, oeb_reg_d;
    logic [NUM_IO-1:0] irq_en_q, irq_en_d;
    logic [NUM_IO-1:0] irq_stat_q, irq_stat_d;
    logic [NUM_IO-1:0] fall_sel;
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic              irq_q, irq_d;

    logic [NUM_IO-1:0] in_sync, in_edge, w1c_mask;
    logic [31:0]       rdata;
    logic [2:0]        ofs;
    logic              hit, req, acc, wr;

`ifdef GPIO_FALLING_EDGE_EN
    logic [NUM_IO-1:0] irq_edge_q, irq_edge_d;
    assign fall_sel = irq_edge_q;
`else
    assign fall_sel = '0;
`endif

    assign hit = ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    assign ofs = wbs_adr_i[4:2];
    // !ack keeps a held strobe from being taken twice (ack every other cycle).
    assign req = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign acc = req & hit;
    assign wr  = acc & wbs_we_i;

    gpio_sync #(
        .WIDTH (NUM_IO)
    ) u_sync (
        .clk_i      (wb_clk_i),
        .rst_i      (wb_rst_i),
        .d_i        (io_in),
        .fall_sel_i (fall_sel),
        .sync_o     (in_sync),
        .edge_o     (in_edge)
    );

    always_comb begin
        rdata = '0;
        case (ofs)
            OFS_SRC_SEL:  rdata[NUM_IO-1:0] = src_sel_q;
            OFS_OUT_DATA: rdata[NUM_IO-1:0] = out_data_q;
            OFS_OEB_REG:  rdata[NUM_IO-1:0] = oeb_reg_q;
            OFS_IN_DATA:  rdata[NUM_IO-1:0] = in_sync;
            OFS_IRQ_EN:   rdata[NUM_IO-1:0] = irq_en_q;
            OFS_IRQ_STAT: rdata[NUM_IO-1:0] = irq_stat_q;
`ifdef GPIO_FALLING_EDGE_EN
            OFS_IRQ_EDGE: rdata[NUM_IO-1:0] = irq_edge_q;
`endif
            default:      rdata = '0;
        endcase
    end

    assign w1c_mask = (wr && ofs == OFS_IRQ_STAT) ? lane_merge('0, wbs_dat_i, wbs_sel_i) : '0;

    always_comb begin
        src_sel_d  = src_sel_q;
        out_data_d = out_data_q;
        oeb_reg_d  = oeb_reg_q;
        irq_en_d   = irq_en_q;
`ifdef GPIO_FALLING_EDGE_EN
        irq_edge_d = irq_edge_q;
`endif
        if (wr) begin
            case (ofs)
                OFS_SRC_SEL:  src_sel_d  = lane_merge(src_sel_q, wbs_dat_i, wbs_sel_i);
                OFS_OUT_DATA: out_data_d = lane_merge(out_data_q, wbs_dat_i, wbs_sel_i);
                OFS_OEB_REG:  oeb_reg_d  = lane_merge(oeb_reg_q, wbs_dat_i, wbs_sel_i);
                OFS_IRQ_EN:   irq_en_d   = lane_merge(irq_en_q, wbs_dat_i, wbs_sel_i);
`ifdef GPIO_FALLING_EDGE_EN
                OFS_IRQ_EDGE: irq_edge_d = lane_merge(irq_edge_q, wbs_dat_i, wbs_sel_i);
`endif
                default: ;
            endcase
        end
        // Set after clear: a new edge wins over a same-cycle W1C.
        irq_stat_d = (irq_stat_q & ~w1c_mask) | in_edge;
        ack_d      = acc;
        // Any read strobe loads the read register; a miss returns 0.
        dat_d      = (req & ~wbs_we_i) ? (hit ? rdata : 32'h0) : dat_q;
        irq_d      = |(irq_stat_q & irq_en_q);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            src_sel_q  <= RST_SRC_SEL[NUM_IO-1:0];
            out_data_q <= RST_OUT_DATA[NUM_IO-1:0];
            oeb_reg_q  <= RST_OEB_REG[NUM_IO-1:0];
            irq_en_q   <= RST_IRQ_EN[NUM_IO-1:0];
            irq_stat_q <= RST_IRQ_STAT[NUM_IO-1:0];
`ifdef GPIO_FALLING_EDGE_EN
            irq_edge_q <= RST_IRQ_EDGE[NUM_IO-1:0];
`endif
            ack_q      <= 1'b0;
            dat_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            src_sel_q  <= src_sel_d;
            out_data_q <= out_data_d;
            oeb_reg_q  <= oeb_reg_d;
            irq_en_q   <= irq_en_d;
            irq_stat_q <= irq_stat_d;
`ifdef GPIO_FALLING_EDGE_EN
            irq_edge_q <= irq_edge_d;
`endif
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            irq_q      <= irq_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = irq_q;

    assign io_out = (src_sel_q & out_data_q) | (~src_sel_q & core_io_out);
    assign io_oeb = (src_sel_q & oeb_reg_q) | (~src_sel_q & core_io_oeb);

endmodule

// File: doc/wb_gpio_mux.md
Name: wb_gpio_mux

Overview:
- Parametrised Wishbone-controlled pad router for the user project area; successor to the fixed "all outputs on, core drives pads" routing.
- Per pin: the pad is driven either by the user core or by a software register; per-pin output enable.
- Synchronised input readback and sticky edge interrupts with a single IRQ line.
- Sits between the user core (e.g. the gfx demo) and io_out/io_oeb/io_in.

Parameters:
- NUM_IO, 16, number of routed pins (1..32).
- BASE_ADDR, 32'h3000_0000, Wishbone base address of the register block.
- ADDR_MASK, 32'hFFFF_FFE0, mask applied to wbs_adr_i before comparing with BASE_ADDR.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- core_io_out  in  NUM_IO  pad values from the user core.
- core_io_oeb  in  NUM_IO  output-enable-bar from the user core.
- io_in  in  NUM_IO  raw pad inputs (asynchronous).
- io_out  out  NUM_IO  pad outputs.
- io_oeb  out  NUM_IO  pad output-enable-bar (0 = drive).
- irq  out  1  level interrupt.

Behaviour:
- Clocking/reset: one clock, wb_clk_i. wb_rst_i is synchronous and active-high.
- Reset values:
  - SRC_SEL=0 (core owns all pins), OUT_DATA=0, OEB_REG=all 1, IRQ_EN=0, IRQ_STAT=0.
  - Synchroniser flops = 0.
  - wbs_ack_o=0, wbs_dat_o=0, irq=0.
- Address decode:
  - hit = ((wbs_adr_i & ADDR_MASK) == BASE_ADDR); register offset = wbs_adr_i[4:2].
  - No hit: no ack; wbs_dat_o=0.
- Register map (bits above NUM_IO read 0 and ignore writes):
  - 0x00 SRC_SEL (rw): bit=1 means the register drives the pin.
  - 0x04 OUT_DATA (rw).
  - 0x08 OEB_REG (rw).
  - 0x0C IN_DATA (ro, synchronised io_in).
  - 0x10 IRQ_EN (rw).
  - 0x14 IRQ_STAT (W1C).
  - 0x18 IRQ_EDGE: see Optional Feature.
  - Other offsets: acked, read 0, writes ignored.
- Wishbone, classic single-access:
  - Access is taken when cyc & stb & hit & !ack are sampled at a rising edge.
  - On that edge: the write commits (byte lanes per wbs_sel_i) and read data is registered into wbs_dat_o.
  - wbs_ack_o=1 for exactly the next cycle, then 0; every access has 1-cycle latency.
  - Back-to-back strobes are acked every other cycle.
  - wbs_dat_o holds its value until the next read.
- Pad mux (combinational from registers):
  - io_out[i] = SRC_SEL[i] ? OUT_DATA[i] : core_io_out[i].
  - io_oeb[i] = SRC_SEL[i] ? OEB_REG[i] : core_io_oeb[i].
  - A register write is visible on the pad from the edge that raises ack.
- Input path:
  - 2-flop synchroniser, then a third "previous" flop.
  - IN_DATA = stage 2, visible 2 edges after the pin change.
  - Rising edge detected when stage 2 = 1 and prev = 0; the matching IRQ_STAT bit sets on that edge, 3 edges after the pin change.
  - IRQ_STAT bits set regardless of IRQ_EN.
- irq: registered, irq = |(IRQ_STAT & IRQ_EN), one edge after a status or enable change.
- W1C write and new edge on the same bit in the same cycle: set wins (bit stays 1).
- Reset mid-access: ack is dropped, the write is discarded, all registers take reset values.

Optional Feature:
- Macro GPIO_FALLING_EDGE_EN.
- Defined:
  - Offset 0x18 IRQ_EDGE (rw, reset 0).
  - Bit=1 selects falling-edge detection for that pin (stage 2 = 0, prev = 1).
- Undefined:
  - 0x18 behaves as an undefined offset (ack, read 0, writes ignored).
  - Rising-edge detection only.

Decomposition:
- Package gpio_mux_pkg: register offset constants (OFS_SRC_SEL..OFS_IRQ_EDGE) and the reset value constants.
- Sub-module gpio_sync: per-bit 2-flop synchroniser, prev flop and edge-pulse output; instantiated NUM_IO wide.

Test Plan:
- Reset state: assert wb_rst_i 2 cycles, core_io_out=16'hA5A5, core_io_oeb=0 -> io_out=16'hA5A5, io_oeb=0, irq=0, read 0x08 returns 16'hFFFF.
- Ownership switch: write OUT_DATA=16'h00F0, OEB_REG=0, SRC_SEL=16'h00FF -> io_out=16'hA5F0; ack exactly 1 cycle per access; read-back values match.
- Byte enables: write 0x04 with data 32'h1234, sel=4'b0010 over prior OUT_DATA=0 -> OUT_DATA=16'h1200.
- Edge interrupt: IRQ_EN=16'h0001; raise io_in[0] -> IRQ_STAT[0]=1 on the 3rd edge, irq=1 on the 4th.
  - Write 1 to 0x14 -> IRQ_STAT[0]=0 and irq=0 one cycle later.
  - Repeat with the W1C and the edge in the same cycle -> IRQ_STAT[0] stays 1.
- Decode: address BASE_ADDR+0x40 -> no ack; BASE_ADDR+0x1C -> ack, read 0.
  - With GPIO_FALLING_EDGE_EN: IRQ_EDGE=1, fall io_in[0] -> IRQ_STAT[0]=1.
  - Without GPIO_FALLING_EDGE_EN: 0x18 reads 0.
- Reset mid-write: assert wb_rst_i in the strobe cycle of a SRC_SEL write -> no ack, SRC_SEL=0.
